// File: rtl/id_ex_pipeline_reg.sv
// id_ex_pipeline_reg: ID/EX pipeline register with load-use bubble insertion, stall and flush.
// Define ID_EX_PERF_EN to enable the saturating bubble counter on bubble_cnt.
module id_ex_pipeline_reg #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        ex_ctrl_in,
    input  logic [2:0]        mem_ctrl_in,
    input  logic [1:0]        wb_ctrl_in,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] pc4_in,
    input  logic [DATA_W-1:0] rd1_in,
    input  logic [DATA_W-1:0] rd2_in,
    input  logic [DATA_W-1:0] imm_in,
    input  logic [4:0]        rs_in,
    input  logic [4:0]        rt_in,
    input  logic [4:0]        rd_in,
    input  logic              stall,
    input  logic              flush,
    output logic [3:0]        ex_ctrl_out,
    output logic [2:0]        mem_ctrl_out,
    output logic [1:0]        wb_ctrl_out,
    output logic [DATA_W-1:0] pc4_out,
    output logic [DATA_W-1:0] rd1_out,
    output logic [DATA_W-1:0] rd2_out,
    output logic [DATA_W-1:0] imm_out,
    output logic [4:0]        rs_out,
    output logic [4:0]        rt_out,
    output logic [4:0]        rd_out,
    output logic              valid_out,
    output logic              hazard_stall,
    output logic [CNT_W-1:0]  bubble_cnt
);
    logic do_bubble;

    // Load in EX whose destination matches an ID source: insert one bubble.
    always_comb begin
        hazard_stall = valid_out & mem_ctrl_out[1] & valid_in & (|rt_out) &
                       ((rt_out == rs_in) | (rt_out == rt_in));
        do_bubble    = hazard_stall & ~flush & ~stall;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ctrl_out  <= '0;
            mem_ctrl_out <= '0;
            wb_ctrl_out  <= '0;
            valid_out    <= 1'b0;
            pc4_out      <= '0;
            rd1_out      <= '0;
            rd2_out      <= '0;
            imm_out      <= '0;
            rs_out       <= '0;
            rt_out       <= '0;
            rd_out       <= '0;
        end else if (flush) begin
            ex_ctrl_out  <= '0;
            mem_ctrl_out <= '0;
            wb_ctrl_out  <= '0;
            valid_out    <= 1'b0;
        end else if (!stall) begin
            ex_ctrl_out  <= (valid_in && !hazard_stall) ? ex_ctrl_in  : '0;
            mem_ctrl_out <= (valid_in && !hazard_stall) ? mem_ctrl_in : '0;
            wb_ctrl_out  <= (valid_in && !hazard_stall) ? wb_ctrl_in  : '0;
            valid_out    <= valid_in & ~hazard_stall;
            pc4_out      <= pc4_in;
            rd1_out      <= rd1_in;
            rd2_out      <= rd2_in;
            imm_out      <= imm_in;
            rs_out       <= rs_in;
            rt_out       <= rt_in;
            rd_out       <= rd_in;
        end
    end

`ifdef ID_EX_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bubble_cnt <= '0;
        else if (do_bubble && !(&bubble_cnt))
            bubble_cnt <= bubble_cnt + 1'b1;
    end
`else
    assign bubble_cnt = '0;
`endif
endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// tb_id_ex_pipeline_reg: directed plus randomized checks against a rule-level model of the ID/EX register.
module tb_id_ex_pipeline_reg;
    localparam int DW = 32;
    localparam int CW = 2;
`ifdef ID_EX_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0;
    logic [3:0] ex_ctrl_in = '0, ex_ctrl_out;
    logic [2:0] mem_ctrl_in = '0, mem_ctrl_out;
    logic [1:0] wb_ctrl_in = '0, wb_ctrl_out;
    logic valid_in = 1'b0, valid_out, stall = 1'b0, flush = 1'b0, hazard_stall;
    logic [DW-1:0] pc4_in = '0, rd1_in = '0, rd2_in = '0, imm_in = '0;
    logic [DW-1:0] pc4_out, rd1_out, rd2_out, imm_out;
    logic [4:0] rs_in = '0, rt_in = '0, rd_in = '0, rs_out, rt_out, rd_out;
    logic [CW-1:0] bubble_cnt;
    int n_chk = 0, n_fail = 0;

    id_ex_pipeline_reg #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_ctrl_in(ex_ctrl_in), .mem_ctrl_in(mem_ctrl_in), .wb_ctrl_in(wb_ctrl_in),
        .valid_in(valid_in), .pc4_in(pc4_in), .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in),
        .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in), .stall(stall), .flush(flush),
        .ex_ctrl_out(ex_ctrl_out), .mem_ctrl_out(mem_ctrl_out), .wb_ctrl_out(wb_ctrl_out),
        .pc4_out(pc4_out), .rd1_out(rd1_out), .rd2_out(rd2_out), .imm_out(imm_out),
        .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out), .valid_out(valid_out),
        .hazard_stall(hazard_stall), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    // Reference state: what EX should hold, plus the number of bubbles seen.
    typedef struct {
        logic [3:0] ex; logic [2:0] mem; logic [1:0] wb; logic v;
        logic [DW-1:0] pc4, rd1, rd2, imm; logic [4:0] rs, rt, rd;
        int cnt;
    } st_t;
    st_t m;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit exp_haz();
        return m.v && m.mem[1] && valid_in && m.rt != 0 && (m.rt == rs_in || m.rt == rt_in);
    endfunction

    task automatic model_reset();
        m = '{ex: 0, mem: 0, wb: 0, v: 0, pc4: 0, rd1: 0, rd2: 0, imm: 0, rs: 0, rt: 0, rd: 0, cnt: 0};
    endtask

    // One edge of the pipeline, expressed as the action chosen by priority.
    task automatic model_edge();
        string act;
        if (!rst_n) return;
        act = flush ? "flush" : stall ? "stall" : exp_haz() ? "bubble" : "load";
        if (act == "stall") return;
        if (act != "flush") begin
            m.pc4 = pc4_in; m.rd1 = rd1_in; m.rd2 = rd2_in; m.imm = imm_in;
            m.rs = rs_in; m.rt = rt_in; m.rd = rd_in;
        end
        if (act == "load" && valid_in) begin
            m.ex = ex_ctrl_in; m.mem = mem_ctrl_in; m.wb = wb_ctrl_in; m.v = 1'b1;
        end else begin
            m.ex = 0; m.mem = 0; m.wb = 0; m.v = 0;
        end
        if (act == "bubble" && m.cnt < (1 << CW) - 1) m.cnt++;
    endtask

    task automatic chk_all();
        check("ex_ctrl", ex_ctrl_out, m.ex);
        check("mem_ctrl", mem_ctrl_out, m.mem);
        check("wb_ctrl", wb_ctrl_out, m.wb);
        check("valid", valid_out, m.v);
        check("pc4", pc4_out, m.pc4);
        check("rd1", rd1_out, m.rd1);
        check("rd2", rd2_out, m.rd2);
        check("imm", imm_out, m.imm);
        check("rs", rs_out, m.rs);
        check("rt", rt_out, m.rt);
        check("rd", rd_out, m.rd);
        check("hazard", hazard_stall, exp_haz());
        check("bubble_cnt", bubble_cnt, PERF ? m.cnt : 0);
    endtask

    // Checks the combinational hazard before the edge, the registered state after it.
    task automatic tick();
        #1 check("hazard_pre", hazard_stall, exp_haz());
        @(posedge clk);
        model_edge();
        #1 chk_all();
    endtask

    task automatic drive(input logic [3:0] ex, input logic [2:0] mem, input logic [1:0] wb,
                         input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        ex_ctrl_in = ex; mem_ctrl_in = mem; wb_ctrl_in = wb; valid_in = v;
        rs_in = rs; rt_in = rt; rd_in = rd;
        pc4_in = $urandom; rd1_in = $urandom; rd2_in = $urandom; imm_in = $urandom;
        stall = 1'b0; flush = 1'b0;
    endtask

    task automatic rnd_in();
        drive(4'($urandom), 3'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom));
        stall = ($urandom_range(0, 7) == 0);
        flush = ($urandom_range(0, 9) == 0);
    endtask

    initial begin
        model_reset();
        #2 chk_all();
        #6 rst_n = 1'b1;
        // Reset then an R-format load
        drive(4'b1100, 3'b000, 2'b10, 1'b1, 5'd1, 5'd2, 5'd3);
        rd1_in = 5; rd2_in = 7;
        tick();
        check("rformat_valid", valid_out, 1'b1);
        // Load-use: lw into r8, then consumer reading r8
        drive(4'b0011, 3'b010, 2'b11, 1'b1, 5'd4, 5'd8, 5'd0);
        tick();
        drive(4'b1100, 3'b000, 2'b10, 1'b1, 5'd8, 5'd9, 5'd10);
        #1 check("lu_haz", hazard_stall, 1'b1);
        tick();
        check("lu_bubble_valid", valid_out, 1'b0);
        check("lu_haz_after", hazard_stall, 1'b0);
        tick();
        // lw targeting r0 is never a hazard
        drive(4'b0011, 3'b010, 2'b11, 1'b1, 5'd4, 5'd0, 5'd0);
        tick();
        drive(4'b1100, 3'b000, 2'b10, 1'b1, 5'd0, 5'd0, 5'd5);
        #1 check("r0_haz", hazard_stall, 1'b0);
        tick();
        // Three stalled cycles with changing inputs, then release
        for (int i = 0; i < 3; i++) begin
            rnd_in(); stall = 1'b1; flush = 1'b0;
            tick();
        end
        rnd_in(); stall = 1'b0; flush = 1'b0;
        tick();
        // Flush wins over a pending bubble
        drive(4'b0011, 3'b010, 2'b11, 1'b1, 5'd4, 5'd6, 5'd0);
        tick();
        drive(4'b1100, 3'b000, 2'b10, 1'b1, 5'd6, 5'd1, 5'd2);
        flush = 1'b1;
        tick();
        // Asynchronous reset between edges, then saturate the counter
        drive(4'b1100, 3'b000, 2'b10, 1'b1, 5'd1, 5'd2, 5'd3);
        tick();
        #2 rst_n = 1'b0;
        model_reset();
        #1 chk_all();
        #3 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(4'b0011, 3'b010, 2'b11, 1'b1, 5'd2, 5'd1, 5'd0);
            tick();
            drive(4'b1100, 3'b000, 2'b10, 1'b1, 5'd1, 5'd0, 5'd3);
            tick();
        end
        check("cnt_sat", bubble_cnt, PERF ? 2'd3 : 2'd0);
        // Random traffic with occasional asynchronous resets
        for (int i = 0; i < 400; i++) begin
            rnd_in();
            if ($urandom_range(0, 99) == 0) begin
                #2 rst_n = 1'b0;
                model_reset();
                #1 chk_all();
                #2 rst_n = 1'b1;
            end
            tick();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
